// File: rtl/mac_seq_ctrl_if.sv
// Handshake bundle between the MAC sequencer and its host / datapath.
// The master drives the job controls and mul_done; the slave is the sequencer.
interface mac_seq_ctrl_if #(
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic             abort;
  logic             continuous;
  logic             mul_done;
  logic             busy;
  logic             done;
  logic             acc_clr_n;
  logic             load_op;
  logic             begin_mul;
  logic             add;
  logic [CNT_W-1:0] term_idx;
  logic             timeout_err;

  modport master (
    output start, abort, continuous, mul_done,
    input  busy, done, acc_clr_n, load_op, begin_mul, add, term_idx, timeout_err
  );

  modport slave (
    input  start, abort, continuous, mul_done,
    output busy, done, acc_clr_n, load_op, begin_mul, add, term_idx, timeout_err
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequencer for an N-term multiply-accumulate job: clear, then per term load/launch/wait/add.
// Moore outputs decoded from the state register; multiplier watchdog drops into a sticky error.
module mac_seq_ctrl #(
  parameter int unsigned NUM_TERMS   = 10,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned MUL_TIMEOUT = 64,
  parameter int unsigned TO_W        = 7
) (
  input logic           clk,
  input logic           reset,
  mac_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StInit = 3'd1,
    StLoad = 3'd2,
    StRun  = 3'd3,
    StWait = 3'd4,
    StAdd  = 3'd5,
    StDone = 3'd6,
    StErr  = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] IdxLast  = CNT_W'(NUM_TERMS - 1);
  // Guarded so a disabled watchdog (MUL_TIMEOUT == 0) never wraps to all-ones.
  localparam logic [TO_W-1:0]  WdogLast = TO_W'((MUL_TIMEOUT == 0) ? 0 : MUL_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [TO_W-1:0]  wdog_q, wdog_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wdog_d  = wdog_q;
    if (bus.abort && (state_q != StIdle)) begin
      state_d = StIdle;
      idx_d   = '0;
    end else begin
      case (state_q)
        StIdle: if (bus.start) state_d = StInit;
        StInit: begin
          idx_d   = '0;
          state_d = StLoad;
        end
        StLoad: state_d = StRun;
        StRun: begin
          wdog_d  = '0;
          state_d = StWait;
        end
        StWait: begin
          if (bus.mul_done) begin
            state_d = StAdd;
          end else if ((MUL_TIMEOUT != 0) && (wdog_q == WdogLast)) begin
            state_d = StErr;
          end else begin
            wdog_d = wdog_q + TO_W'(1);
          end
        end
        StAdd: begin
          if (idx_q == IdxLast) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            state_d = StLoad;
          end
        end
        StDone: state_d = bus.continuous ? StInit : StIdle;
        StErr:  if (bus.start) state_d = StInit;
        default: begin
          state_d = StIdle;
          idx_d   = '0;
        end
      endcase
    end
  end

  assign bus.busy        = (state_q != StIdle) && (state_q != StErr);
  assign bus.done        = (state_q == StDone);
  // Reset term keeps the accumulator cleared while reset is held, independent of the clock.
  assign bus.acc_clr_n   = reset && (state_q != StInit);
  assign bus.load_op     = (state_q == StLoad);
  assign bus.begin_mul   = (state_q == StRun);
  assign bus.add         = (state_q == StAdd);
  assign bus.term_idx    = idx_q;
  assign bus.timeout_err = (state_q == StErr);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: vector table, directed job sequences and random traffic,
// all cross-checked every cycle against a job-level reference model.
module tb_mac_seq_ctrl;

  localparam int NT = 10;
  localparam int CW = 4;
  localparam int TO = 64;
  localparam int TW = 7;
  localparam int OW = 7 + CW;

  typedef logic [OW-1:0] out_t;
  typedef enum int {PIdle, PErr, PInit, PLoad, PRun, PWait, PAdd, PDone} phase_t;
  typedef struct {
    logic st;
    logic ab;
    logic co;
    logic md;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.CNT_W(CW)) bus ();

  mac_seq_ctrl #(
    .NUM_TERMS  (NT),
    .CNT_W      (CW),
    .MUL_TIMEOUT(TO),
    .TO_W       (TW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: job phase, current term and WAIT cycles already spent on it.
  phase_t ph = PIdle;
  int     m_term = 0;
  int     m_waited = 0;

  int cyc = 0, n_load = 0, n_add = 0, n_done = 0, n_clr = 0, n_wait = 0, n_notbusy = 0;
  int t_init = 0, t_done = 0;

  function automatic out_t mk(input logic b, d, c, l, m, a, e, input int i);
    return {b, d, c, l, m, a, e, CW'(i)};
  endfunction

  function automatic out_t dut_out();
    return {bus.busy, bus.done, bus.acc_clr_n, bus.load_op, bus.begin_mul, bus.add,
            bus.timeout_err, bus.term_idx};
  endfunction

  function automatic out_t model_out();
    return mk((ph != PIdle) && (ph != PErr), ph == PDone, ph != PInit, ph == PLoad,
              ph == PRun, ph == PAdd, ph == PErr, m_term);
  endfunction

  task automatic model_step(input logic st, ab, co, md);
    if (ab && ph != PIdle) begin
      ph = PIdle;
      m_term = 0;
    end else begin
      case (ph)
        PIdle, PErr: if (st) ph = PInit;
        PInit: begin m_term = 0; ph = PLoad; end
        PLoad: ph = PRun;
        PRun:  begin m_waited = 0; ph = PWait; end
        PWait: begin
          if (md) ph = PAdd;
          else if (TO != 0 && m_waited + 1 == TO) ph = PErr;
          else m_waited++;
        end
        PAdd: begin
          if (m_term == NT - 1) ph = PDone;
          else begin m_term++; ph = PLoad; end
        end
        PDone: ph = co ? PInit : PIdle;
        default: ph = PIdle;
      endcase
    end
  endtask

  task automatic model_reset();
    ph = PIdle;
    m_term = 0;
    m_waited = 0;
  endtask

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_cnt();
    n_load = 0; n_add = 0; n_done = 0; n_clr = 0; n_wait = 0; n_notbusy = 0;
    t_init = 0; t_done = 0;
  endtask

  // One clock: drive on negedge, model advances on posedge, compare 1 time unit later.
  task automatic cycle(input logic st, ab, co, md);
    @(negedge clk);
    bus.start = st; bus.abort = ab; bus.continuous = co; bus.mul_done = md;
    @(posedge clk);
    model_step(st, ab, co, md);
    #1;
    check("model", dut_out(), model_out());
    cyc++;
    if (bus.load_op) n_load++;
    if (bus.add) n_add++;
    if (bus.done) begin n_done++; if (t_done == 0) t_done = cyc; end
    if (!bus.acc_clr_n) begin n_clr++; if (t_init == 0) t_init = cyc; end
    if (!bus.busy) n_notbusy++;
    if (bus.busy && bus.acc_clr_n && !bus.done && !bus.load_op && !bus.begin_mul && !bus.add)
      n_wait++;
  endtask

  // Serve the multiplier with latency L (mul_done seen on WAIT cycle L).
  function automatic logic mul_resp(input int lat);
    return (ph == PWait) && (m_waited == lat - 1);
  endfunction

  task automatic run_to_wait(input int term, input int lat, input logic co);
    for (int k = 0; k < 400 && !(ph == PWait && m_term == term); k++)
      cycle(1'b0, 1'b0, co, mul_resp(lat));
  endtask

  task automatic run_to_done(input int lat, input int max_done);
    for (int k = 0; k < 400 && n_done < max_done; k++) cycle(1'b0, 1'b0, 1'b0, mul_resp(lat));
  endtask

  vec_t tbl[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.continuous = 1'b0; bus.mul_done = 1'b0;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 1, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 1, 0, 0, 0, 0, 0)};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 0, 1, 1, 0, 0, 0, 0)};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 1, 0, 0, 0)};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 0, 0, 0, 0)};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 0, 0, 0, 0)};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 0, 1, 0, 0, 1, 0, 0)};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(1, 0, 1, 1, 0, 0, 0, 1)};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 0, 1, 0, 1, 0, 0, 1)};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 0, 1, 0, 0, 0, 0, 1)};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1, 0, 1, 0, 0, 1, 0, 1)};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, mk(1, 0, 1, 1, 0, 0, 0, 2)};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, mk(0, 0, 1, 0, 0, 0, 0, 0)};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0)};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, mk(0, 0, 1, 0, 0, 0, 0, 0)};

    // Reset state, including acc_clr_n held low by reset itself.
    #1;
    check("reset_state", dut_out(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("after_release", dut_out(), mk(0, 0, 1, 0, 0, 0, 0, 0));

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].st, tbl[i].ab, tbl[i].co, tbl[i].md);
      check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end

    // T1: ten terms, latency 2 -> done 51 cycles after INIT.
    clr_cnt();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_to_done(2, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_int("t1_done_cnt", n_done, 1);
    check_int("t1_load_cnt", n_load, NT);
    check_int("t1_add_cnt", n_add, NT);
    check_int("t1_clr_cycles", n_clr, 1);
    check_int("t1_init_to_done", t_done - t_init, 1 + NT * (3 + 2));

    // T2: multiplier never answers -> ERR after 64 WAIT cycles; sticky until start.
    clr_cnt();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 200 && !bus.timeout_err; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_int("t2_wait_cycles", n_wait, TO);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("t2_err_sticky", dut_out(), mk(0, 0, 1, 0, 0, 0, 1, 0));
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_restart", dut_out(), mk(1, 0, 0, 0, 0, 0, 0, 0));
    run_to_done(1, 1);
    check_int("t2_job_done", n_done, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // T3: abort in WAIT of term 5, then abort racing mul_done in term 2.
    clr_cnt();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_to_wait(5, 1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("t3_abort", dut_out(), mk(0, 0, 1, 0, 0, 0, 0, 0));
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_to_wait(2, 1, 1'b0);
    n_add = 0;
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_int("t3_no_add", n_add, 0);
    check_int("t3_no_done", n_done, 0);

    // T4: continuous mode, two back-to-back jobs without dropping busy.
    clr_cnt();
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    n_notbusy = 0;
    for (int k = 0; k < 400 && n_done < 2; k++) cycle(1'b0, 1'b0, 1'b1, mul_resp(1));
    check_int("t4_done_cnt", n_done, 2);
    check_int("t4_busy_gap", n_notbusy, 0);
    check_int("t4_init_cnt", n_clr, 2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // T5: start held while busy, mul_done in LOAD/RUN ignored.
    clr_cnt();
    for (int k = 0; k < 400 && n_done == 0; k++)
      cycle(1'b1, 1'b0, 1'b0, (ph == PLoad) || (ph == PRun) || mul_resp(3));
    check_int("t5_done_cnt", n_done, 1);
    check_int("t5_init_cnt", n_clr, 1);
    check_int("t5_init_to_done", t_done - t_init, 1 + NT * (3 + 3));
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // T6: asynchronous reset during term 3, then idle until a new start.
    clr_cnt();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_to_wait(3, 2, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    check("t6_async_reset", dut_out(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
    @(negedge clk);
    bus.start = 1'b0; bus.mul_done = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_int("t6_no_done", n_done, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_to_done(1, 1);
    check_int("t6_job_done", n_done, 1);

    // Random traffic: frequent multiplier answers, then a starving phase to hit timeouts.
    for (int k = 0; k < 3000; k++) begin
      logic st, ab, co, md;
      st = ($urandom_range(0, 7) == 0);
      ab = ($urandom_range(0, 59) == 0);
      co = ($urandom_range(0, 3) == 0);
      md = (k < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
      cycle(st, ab, co, md);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
